// File: rtl/ad9866_gain_sched.sv
// AD9866 gain write scheduler: settles RX/TX gain inputs and issues
// one-at-a-time write requests to the SPI controller.

module ad9866_gain_chan #(
  parameter int SETTLE = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] gain_in,
  input  logic       grant,
  input  logic [5:0] code,
  output logic       pending,
  output logic [5:0] stl_code
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SMAX = CW'(SETTLE);

  logic [5:0]    prev;
  logic [5:0]    sent;
  logic [CW-1:0] cnt;
  logic          stable;
  logic          settled;
  logic          fresh;

  always_comb begin
    stable  = (gain_in == prev);
    settled = stable && (cnt == SMAX);
    fresh   = settled && (gain_in != sent);
  end

  // The change cycle itself counts as the first constant cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev     <= '0;
      sent     <= '0;
      cnt      <= '0;
      pending  <= 1'b1;
      stl_code <= '0;
    end else begin
      prev <= gain_in;
      if (!stable)
        cnt <= CW'(1);
      else if (cnt != SMAX)
        cnt <= cnt + CW'(1);
      if (settled)
        stl_code <= gain_in;
      if (grant) begin
        sent    <= code;
        pending <= settled && (gain_in != code);
      end else if (fresh) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

module ad9866_gain_sched #(
  parameter int HOLDOFF = 128,
  parameter int SETTLE  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] rx_gain_in,
  input  logic [5:0] tx_gain_in,
  input  logic       sen_n,
  output logic       ext_rx_rqst,
  output logic       ext_tx_rqst,
  output logic [5:0] rx_gain,
  output logic [5:0] tx_gain,
  output logic       busy,
  output logic       rqst_timeout
);

  localparam int CMAX = (HOLDOFF > TIMEOUT) ? HOLDOFF : TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] HOLD_END = CW'(HOLDOFF - 1);
  localparam logic [CW-1:0] TO_END   = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_IDLE,
    S_REQ,
    S_XFER
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          rx_rq_n;
  logic          tx_rq_n;
  logic [5:0]    rx_code_n;
  logic [5:0]    tx_code_n;
  logic          last_tx;
  logic          last_tx_n;
  logic          to_n;
  logic          rx_grant;
  logic          tx_grant;
  logic          rx_pend;
  logic          tx_pend;
  logic [5:0]    rx_stl;
  logic [5:0]    tx_stl;

  ad9866_gain_chan #(
    .SETTLE (SETTLE)
  ) u_rx (
    .clk      (clk),
    .reset_n  (reset_n),
    .gain_in  (rx_gain_in),
    .grant    (rx_grant),
    .code     (rx_gain),
    .pending  (rx_pend),
    .stl_code (rx_stl)
  );

  ad9866_gain_chan #(
    .SETTLE (SETTLE)
  ) u_tx (
    .clk      (clk),
    .reset_n  (reset_n),
    .gain_in  (tx_gain_in),
    .grant    (tx_grant),
    .code     (tx_gain),
    .pending  (tx_pend),
    .stl_code (tx_stl)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    rx_rq_n   = ext_rx_rqst;
    tx_rq_n   = ext_tx_rqst;
    rx_code_n = rx_gain;
    tx_code_n = tx_gain;
    last_tx_n = last_tx;
    to_n      = rqst_timeout;
    rx_grant  = 1'b0;
    tx_grant  = 1'b0;
    unique case (state)
      S_HOLD: begin
        if (cnt == HOLD_END) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_IDLE: begin
        if (sen_n && (rx_pend || tx_pend)) begin
          state_n = S_REQ;
          cnt_n   = '0;
          // Alternate when both wait; RX first after reset.
          if (rx_pend && (!tx_pend || last_tx)) begin
            rx_rq_n   = 1'b1;
            rx_code_n = rx_stl;
            last_tx_n = 1'b0;
          end else begin
            tx_rq_n   = 1'b1;
            tx_code_n = tx_stl;
            last_tx_n = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (!sen_n) begin
          rx_grant = ext_rx_rqst;
          tx_grant = ext_tx_rqst;
          rx_rq_n  = 1'b0;
          tx_rq_n  = 1'b0;
          state_n  = S_XFER;
        end else if (cnt == TO_END) begin
          rx_rq_n = 1'b0;
          tx_rq_n = 1'b0;
          to_n    = 1'b1;
          state_n = S_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_XFER: begin
        if (sen_n)
          state_n = S_IDLE;
      end
      default: begin
        state_n = S_HOLD;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_HOLD;
      cnt          <= '0;
      ext_rx_rqst  <= 1'b0;
      ext_tx_rqst  <= 1'b0;
      rx_gain      <= '0;
      tx_gain      <= '0;
      last_tx      <= 1'b1;
      rqst_timeout <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      ext_rx_rqst  <= rx_rq_n;
      ext_tx_rqst  <= tx_rq_n;
      rx_gain      <= rx_code_n;
      tx_gain      <= tx_code_n;
      last_tx      <= last_tx_n;
      rqst_timeout <= to_n;
    end
  end

  assign busy = (state != S_IDLE);

endmodule
